// File: rtl/host_proto_pkg.sv
// host_proto_pkg: command bytes, reply length and sequencer states shared by both ends of the UART link
package host_proto_pkg;
    localparam logic [7:0] CMD_CFG   = 8'hA5;
    localparam logic [7:0] CMD_START = 8'h5A;
    localparam int         RPL_BYTES = 8;
    typedef enum logic [1:0] {IDLE, SEND, GAP, WAIT_RX} hs_state_t;
endpackage

// File: rtl/byte_pacer.sv
// byte_pacer: loadable down-counter; expire marks the final cycle of a loaded interval
module byte_pacer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!rstn) cnt <= '0;
        else if (load) cnt <= value;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    // a loaded value v therefore spans exactly v cycles before the owner moves on
    assign expire = cnt <= W'(1);
endmodule

// File: rtl/uart_host_sequencer.sv
// uart_host_sequencer: sends a config frame to control_unit over UART and
// assembles the 8-byte MSE reply into one 64-bit word
module uart_host_sequencer
    import host_proto_pkg::*;
#(
    parameter int NUM_CHAN = 3,
    parameter int BYTE_GAP = 10416,
    parameter int TIMEOUT  = 50000000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  go,
    input  logic [8*NUM_CHAN-1:0] cfg_int,
    input  logic [8*NUM_CHAN-1:0] cfg_frac,
    output logic                  com_txvalid,
    output logic [7:0]            com_txdata,
    input  logic                  com_rxvalid,
    input  logic [7:0]            com_rxdata,
    output logic                  busy,
    output logic [63:0]           mse_data,
    output logic                  done,
    output logic                  timeout
);
    localparam int L  = 2*NUM_CHAN + 2;
    localparam int IW = $clog2(L + 1);
    localparam int GW = BYTE_GAP > 1 ? $clog2(BYTE_GAP) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    hs_state_t      state, state_n;
    logic [IW-1:0]  idx;
    logic [3:0]     rx_cnt;
    logic [8*L-1:0] frame_sr, frame_new;
    logic           gap_load, gap_exp, to_load, to_exp, done_n, timeout_n;

    // whole frame is snapshotted on go and shifted out LSB byte first
    always_comb begin
        frame_new = '0;
        frame_new[7:0] = CMD_CFG;
        for (int k = 0; k < NUM_CHAN; k++) begin
            frame_new[16*k+8 +: 8]  = cfg_int[8*k +: 8];
            frame_new[16*k+16 +: 8] = cfg_frac[8*k +: 8];
        end
        frame_new[8*L-8 +: 8] = CMD_START;
    end

    assign com_txvalid = state == SEND;
    assign com_txdata  = com_txvalid ? frame_sr[7:0] : 8'h00;
    assign busy        = state != IDLE;

    byte_pacer #(.W(GW)) u_gap (
        .clk(clk), .rstn(rstn), .load(gap_load), .value(GW'(BYTE_GAP - 1)), .expire(gap_exp)
    );
    byte_pacer #(.W(TW)) u_tmo (
        .clk(clk), .rstn(rstn), .load(to_load), .value(TW'(TIMEOUT - 1)), .expire(to_exp)
    );

    always_comb begin
        state_n   = state;
        gap_load  = 1'b0;
        to_load   = 1'b0;
        done_n    = 1'b0;
        timeout_n = 1'b0;
        case (state)
            IDLE:    if (go && !done && !timeout) state_n = SEND;
            SEND:    begin
                state_n  = GAP;
                gap_load = 1'b1;
            end
            GAP:     if (gap_exp) begin
                state_n = idx == IW'(L) ? WAIT_RX : SEND;
                to_load = idx == IW'(L);
            end
            WAIT_RX: if (com_rxvalid) begin
                to_load = 1'b1;
                done_n  = rx_cnt == 4'(RPL_BYTES - 1);
                state_n = done_n ? IDLE : WAIT_RX;
            end else if (to_exp) begin
                timeout_n = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            idx      <= '0;
            rx_cnt   <= '0;
            frame_sr <= '0;
            mse_data <= '0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state   <= state_n;
            done    <= done_n;
            timeout <= timeout_n;
            if (state == IDLE && state_n == SEND) begin
                frame_sr <= frame_new;
                idx      <= '0;
            end
            if (state == SEND) begin
                frame_sr <= frame_sr >> 8;
                idx      <= idx + 1'b1;
            end
            if (state == GAP && state_n == WAIT_RX) begin
                rx_cnt   <= '0;
                mse_data <= '0;
            end
            if (state == WAIT_RX && com_rxvalid) begin
                mse_data <= {mse_data[55:0], com_rxdata};
                rx_cnt   <= rx_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_host_sequencer.sv
// tb_uart_host_sequencer: directed scenarios with tx-byte and reply scoreboards
module tb_uart_host_sequencer;
    localparam int NC = 3;
    localparam int G  = 4;
    localparam int TO = 20;
    localparam int L  = 2*NC + 2;

    logic          clk = 1'b0;
    logic          rstn, go, com_rxvalid, com_txvalid, busy, done, timeout;
    logic [8*NC-1:0] cfg_int, cfg_frac;
    logic [7:0]    com_rxdata, com_txdata;
    logic [63:0]   mse_data;

    int checks = 0, errors = 0;
    int cyc = 0, go_cyc = 0, last_tx = 0, last_rx_cyc = 0, exp_to_cyc = -1;
    int tx_seen = 0, done_cnt = 0, to_cnt = 0;
    logic prev_busy;
    logic [7:0]  txq[$];
    logic [63:0] mseq[$];
    logic [63:0] rv;

    uart_host_sequencer #(.NUM_CHAN(NC), .BYTE_GAP(G), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .go(go), .cfg_int(cfg_int), .cfg_frac(cfg_frac),
        .com_txvalid(com_txvalid), .com_txdata(com_txdata),
        .com_rxvalid(com_rxvalid), .com_rxdata(com_rxdata),
        .busy(busy), .mse_data(mse_data), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one cycle and score whatever the DUT produced in it
    task automatic tick();
        prev_busy = busy;
        @(posedge clk);
        #1;
        cyc++;
        if (com_txvalid) begin
            tx_seen++;
            chk("tx_pending", 64'(txq.size() != 0), 1);
            if (txq.size() != 0) chk("tx_byte", com_txdata, txq.pop_front());
            if (tx_seen == 1) chk("first_strobe", cyc, go_cyc + 1);
            else chk("strobe_gap", cyc - last_tx, G);
            last_tx = cyc;
        end
        if (done) begin
            done_cnt++;
            chk("done_cycle", cyc, last_rx_cyc + 1);
            chk("busy_with_done", busy, 0);
            chk("busy_before_done", prev_busy, 1);
            chk("mse_pending", 64'(mseq.size() != 0), 1);
            if (mseq.size() != 0) chk("mse_data", mse_data, mseq.pop_front());
        end
        if (timeout) begin
            to_cnt++;
            chk("timeout_cycle", cyc, exp_to_cyc);
            chk("busy_with_timeout", busy, 0);
        end
    endtask

    task automatic start_frame(input logic [8*NC-1:0] iv, input logic [8*NC-1:0] fv);
        cfg_int  = iv;
        cfg_frac = fv;
        txq.push_back(8'hA5);
        for (int k = 0; k < NC; k++) begin
            txq.push_back(iv[8*k +: 8]);
            txq.push_back(fv[8*k +: 8]);
        end
        txq.push_back(8'h5A);
        tx_seen = 0;
        go_cyc  = cyc;
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 200 && tx_seen < n; i++) tick();
        chk("tx_reached", tx_seen, n);
    endtask

    task automatic finish_frame();
        wait_tx(L);
        repeat (G) tick();
        chk("tx_queue_empty", txq.size(), 0);
        chk("tx_total", tx_seen, L);
    endtask

    task automatic send_rx(input logic [7:0] b);
        com_rxvalid = 1'b1;
        com_rxdata  = b;
        last_rx_cyc = cyc;
        tick();
        com_rxvalid = 1'b0;
        repeat (6) tick();
    endtask

    task automatic send_reply(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) send_rx(v[63-8*i -: 8]);
    endtask

    initial begin
        rstn = 1'b0; go = 1'b0; com_rxvalid = 1'b0; com_rxdata = '0;
        cfg_int = '0; cfg_frac = '0;
        repeat (3) tick();
        rstn = 1'b1;
        chk("rst_txvalid", com_txvalid, 0);
        chk("rst_txdata", com_txdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_mse", mse_data, 0);
        repeat (100) tick();
        chk("idle_no_tx", tx_seen, 0);
        chk("idle_busy", busy, 0);

        // frame format and reply assembly
        start_frame({8'd5, 8'd2, 8'd2}, {8'd24, 8'd12, 8'd12});
        chk("busy_after_go", busy, 1);
        finish_frame();
        mseq.push_back(64'h0123456789ABCDEF);
        send_reply(64'h0123456789ABCDEF, 8);
        chk("reply_done_count", done_cnt, 1);
        chk("reply_idle", busy, 0);
        chk("reply_mse_hold", mse_data, 64'h0123456789ABCDEF);

        // timeout after a partial reply
        start_frame(24'($urandom), 24'($urandom));
        finish_frame();
        send_rx(8'h11);
        send_rx(8'h22);
        send_rx(8'h33);
        exp_to_cyc = last_rx_cyc + TO;
        for (int i = 0; i < 40 && to_cnt == 0; i++) tick();
        chk("timeout_count", to_cnt, 1);
        chk("timeout_no_done", done_cnt, 1);
        chk("timeout_idle", busy, 0);
        exp_to_cyc = -1;
        repeat (5) tick();

        // go while busy, cfg change mid-frame, rx during GAP
        start_frame(24'h030201, 24'h0A0B0C);
        wait_tx(3);
        go = 1'b1;
        tick();
        go = 1'b0;
        cfg_int = 24'hFFFFFF;
        wait_tx(5);
        tick();
        com_rxvalid = 1'b1;
        com_rxdata  = 8'hEE;
        tick();
        com_rxvalid = 1'b0;
        finish_frame();
        rv = {$urandom, $urandom};
        mseq.push_back(rv);
        send_reply(rv, 8);
        chk("ignore_done_count", done_cnt, 2);
        repeat (2 * L * G) tick();
        chk("ignore_no_extra_tx", tx_seen, L);

        // reset in the middle of a reply
        start_frame(24'($urandom), 24'($urandom));
        finish_frame();
        send_reply(64'hDEADBEEF_00000000, 4);
        rstn = 1'b0;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_timeout", timeout, 0);
        chk("midrst_mse", mse_data, 0);
        rstn = 1'b1;
        repeat (30) tick();
        chk("midrst_no_done", done_cnt, 2);
        chk("midrst_no_timeout", to_cnt, 1);
        start_frame(24'h0F0E0D, 24'h151617);
        finish_frame();
        mseq.push_back(64'hFEDCBA9876543210);
        send_reply(64'hFEDCBA9876543210, 8);
        chk("fresh_done_count", done_cnt, 3);
        chk("fresh_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_host_sequencer.md
Name: uart_host_sequencer

Overview:
On-chip host-side initiator for the command/result byte protocol that control_unit serves over UART. It turns a parameter set (per-channel int/frac widths) into a command byte stream for uart_transmitter. It then collects the 8-byte MSE reply from uart_receiver and presents it as one 64-bit word. It is used for board self-test and loopback regression of the word-length sweep without a PC.

Parameters:
NUM_CHAN, 3, number of bit_switch channels configured per run
BYTE_GAP, 10416, clk cycles between successive tx bytes (≥ one UART frame time)
TIMEOUT, 50000000, max clk cycles allowed between reply bytes
CMD_CFG, 8'hA5, frame header byte
CMD_START, 8'h5A, start-run byte terminating a frame

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
go  in  1  single-cycle request to run one frame
cfg_int  in  8*NUM_CHAN  channel k int width at bits [8k+7:8k]
cfg_frac  in  8*NUM_CHAN  channel k frac width at bits [8k+7:8k]
com_txvalid  out  1  one-cycle strobe, byte to uart_transmitter
com_txdata  out  8  tx byte, valid with com_txvalid
com_rxvalid  in  1  one-cycle strobe from uart_receiver
com_rxdata  in  8  rx byte
busy  out  1  high from go acceptance until done/timeout
mse_data  out  64  assembled reply, MSB-first
done  out  1  one-cycle pulse, mse_data valid
timeout  out  1  one-cycle pulse, reply aborted

Behaviour:
- Clocking/reset: one clock, clk. rstn is synchronous and active-low. At reset: state IDLE, com_txvalid=0, com_txdata=0, busy=0, done=0, timeout=0, mse_data=0, all counters=0.
- Reset mid-operation returns to IDLE within one cycle. Any partial frame is abandoned and no pulse is emitted.
- Frame format, L = 2*NUM_CHAN+2 bytes: byte0=CMD_CFG; then for each k=0..NUM_CHAN-1, cfg_int[k] followed by cfg_frac[k]; last byte=CMD_START.
- States: IDLE -> SEND -> GAP -> (SEND | WAIT_RX) -> IDLE.
- IDLE: go=1 registers cfg_int/cfg_frac into a snapshot, clears byte index, sets busy=1, and goes to SEND. go while busy=1 is ignored. Later cfg changes do not affect the running frame.
- SEND: for exactly one cycle, com_txvalid=1 and com_txdata=byte[idx]. Then idx++, gap counter is loaded with BYTE_GAP-1, and the FSM goes to GAP.
- GAP: counts down to 0. If idx<L, go to SEND; otherwise clear the rx count, clear mse_data, load the timeout counter, and go to WAIT_RX.
- First tx strobe is 1 cycle after go. Consecutive strobes are exactly BYTE_GAP cycles apart.
- WAIT_RX: each com_rxvalid shifts mse_data left by 8, inserts com_rxdata at [7:0], increments rx count, and reloads the timeout counter.
- On the 8th byte, done pulses in the same cycle the last byte's shift completes (registered, 1 cycle after that com_rxvalid). busy drops in the same cycle and the FSM returns to IDLE.
- Timeout: if the counter reaches 0 in WAIT_RX, timeout pulses for one cycle, busy=0, and the FSM returns to IDLE. mse_data holds the partial value and is undefined to consumers.
- com_rxvalid outside WAIT_RX, including during SEND/GAP of the own frame, is discarded.
- A go arriving in the same cycle as done/timeout is ignored; it is accepted from IDLE only.
- mse_data holds its last value until the next accepted reply starts.
- Counters: gap counter width $clog2(BYTE_GAP), timeout counter width $clog2(TIMEOUT+1), idx width $clog2(L+1). No wrap is possible, because each counter is bounded by its FSM state.

Decomposition:
- Shared package host_proto_pkg holds CMD_CFG/CMD_START localparams, the state enum type, and the reply length constant RPL_BYTES=8. control_unit imports the same package so both ends agree.
- One natural sub-module: byte_pacer (loadable down-counter with zero flag), reused for the gap and timeout counts.
- Frame byte mux and rx shift register stay in the top module.

Test Plan:
- Reset/idle (NUM_CHAN=3, BYTE_GAP=4): hold rstn=0 for 3 cycles, then release with go=0 -> all outputs 0 and no com_txvalid for 100 cycles.
- Frame format (NUM_CHAN=3, BYTE_GAP=4): cfg_int={5,2,2}, cfg_frac={24,12,12}, pulse go -> bytes A5,02,0C,02,0C,05,18,5A; strobes 4 cycles apart; first strobe 1 cycle after go.
- Reply: after the frame, feed rx 01,23,45,67,89,AB,CD,EF spaced 7 cycles -> done pulse, mse_data=64'h0123456789ABCDEF, busy falls with done.
- Timeout (TIMEOUT=20): after the frame, send 3 reply bytes then stop -> timeout pulses exactly 20 cycles after the 3rd byte, done never asserts, FSM back in IDLE.
- Ignore rules: go pulsed at byte 3 of a frame, and an rx byte injected during GAP -> frame still exactly 8 bytes, and the injected byte is absent from mse_data.
- Reset mid-run: assert rstn=0 during WAIT_RX after 4 reply bytes -> next cycle busy=0 and no done/timeout; a subsequent go produces a complete fresh frame.
